// File: rtl/alu_issue_station.sv
// alu_issue_station
//   Reservation station and issue scheduler for the integer ALU. Holds decoded
//   ALU ops from dispatch, snoops both result broadcast buses for missing
//   operands, and issues at most one ready op per cycle on a registered port.
//
// Ports
//   clk, rst           clock (posedge) and asynchronous active-low reset
//   rdy                global ready; 0 freezes all state and outputs
//   clear              synchronous flush on mispredict
//   disp_*             dispatch request: op fields, operand values and tags
//   full               combinational, no free entry (registered state only)
//   cdbA_*, cdbB_*     ALU / load-store result broadcasts
//   alu_en, alu_*      registered issue port to the ALU
//
// Handshake: a dispatch is accepted on a posedge where rdy & !clear &
// disp_valid & !full; the dispatcher holds its request while full is high.
// alu_en is a one-cycle strobe per issued op with no back-pressure; a held
// alu_en while rdy=0 is not a new op.

module alu_issue_station #(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             disp_valid,
  input  logic [5:0]       disp_opcode,
  input  logic [ROB_W-1:0] disp_rob_id,
  input  logic [31:0]      disp_pc,
  input  logic [31:0]      disp_imm,
  input  logic [31:0]      disp_vj,
  input  logic [31:0]      disp_vk,
  input  logic             disp_qj_busy,
  input  logic [ROB_W-1:0] disp_qj,
  input  logic             disp_qk_busy,
  input  logic [ROB_W-1:0] disp_qk,
  output logic             full,
  input  logic             cdbA_valid,
  input  logic [ROB_W-1:0] cdbA_rob_id,
  input  logic [31:0]      cdbA_value,
  input  logic             cdbB_valid,
  input  logic [ROB_W-1:0] cdbB_rob_id,
  input  logic [31:0]      cdbB_value,
  output logic             alu_en,
  output logic [ROB_W-1:0] alu_rob_id,
  output logic [5:0]       alu_opcode,
  output logic [31:0]      alu_rs1,
  output logic [31:0]      alu_rs2,
  output logic [31:0]      alu_imm,
  output logic [31:0]      alu_pc
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  // Entry storage
  logic [RS_SIZE-1:0] busy_q;
  logic [RS_SIZE-1:0] qj_busy_q;
  logic [RS_SIZE-1:0] qk_busy_q;
  logic [5:0]         opcode_q [RS_SIZE];
  logic [ROB_W-1:0]   rob_id_q [RS_SIZE];
  logic [31:0]        pc_q     [RS_SIZE];
  logic [31:0]        imm_q    [RS_SIZE];
  logic [31:0]        vj_q     [RS_SIZE];
  logic [31:0]        vk_q     [RS_SIZE];
  logic [ROB_W-1:0]   qj_q     [RS_SIZE];
  logic [ROB_W-1:0]   qk_q     [RS_SIZE];

  logic [RS_SIZE-1:0] ready;
  logic               iss_hit;
  logic [IDX_W-1:0]   iss_idx;
  logic               free_hit;
  logic [IDX_W-1:0]   free_idx;

  // Dispatch operands after same-cycle CDB bypass
  logic [31:0]        byp_vj;
  logic [31:0]        byp_vk;
  logic               byp_qj_busy;
  logic               byp_qk_busy;

  // Readiness looks only at registered state, so a wakeup or dispatch this
  // cycle can issue next cycle at the earliest.
  assign ready = busy_q & ~qj_busy_q & ~qk_busy_q;
  assign full  = &busy_q;

  // Lowest-index priority pick for both issue and free-slot allocation:
  // scanning downward lets the lowest matching index win.
  always_comb begin
    iss_hit  = 1'b0;
    iss_idx  = '0;
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        iss_hit = 1'b1;
        iss_idx = IDX_W'(i);
      end
      if (!busy_q[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    byp_vj      = disp_vj;
    byp_qj_busy = disp_qj_busy;
    if (disp_qj_busy && cdbA_valid && (cdbA_rob_id == disp_qj)) begin
      byp_vj      = cdbA_value;
      byp_qj_busy = 1'b0;
    end else if (disp_qj_busy && cdbB_valid && (cdbB_rob_id == disp_qj)) begin
      byp_vj      = cdbB_value;
      byp_qj_busy = 1'b0;
    end
  end

  always_comb begin
    byp_vk      = disp_vk;
    byp_qk_busy = disp_qk_busy;
    if (disp_qk_busy && cdbA_valid && (cdbA_rob_id == disp_qk)) begin
      byp_vk      = cdbA_value;
      byp_qk_busy = 1'b0;
    end else if (disp_qk_busy && cdbB_valid && (cdbB_rob_id == disp_qk)) begin
      byp_vk      = cdbB_value;
      byp_qk_busy = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      qj_busy_q  <= '0;
      qk_busy_q  <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        opcode_q[i] <= '0;
        rob_id_q[i] <= '0;
        pc_q[i]     <= '0;
        imm_q[i]    <= '0;
        vj_q[i]     <= '0;
        vk_q[i]     <= '0;
        qj_q[i]     <= '0;
        qk_q[i]     <= '0;
      end
      alu_en     <= 1'b0;
      alu_rob_id <= '0;
      alu_opcode <= '0;
      alu_rs1    <= '0;
      alu_rs2    <= '0;
      alu_imm    <= '0;
      alu_pc     <= '0;
    end else if (rdy) begin
      if (clear) begin
        busy_q <= '0;
        alu_en <= 1'b0;
      end else begin
        // Issue
        alu_en <= iss_hit;
        if (iss_hit) begin
          alu_rob_id       <= rob_id_q[iss_idx];
          alu_opcode       <= opcode_q[iss_idx];
          alu_rs1          <= vj_q[iss_idx];
          alu_rs2          <= vk_q[iss_idx];
          alu_imm          <= imm_q[iss_idx];
          alu_pc           <= pc_q[iss_idx];
          busy_q[iss_idx]  <= 1'b0;
        end

        // Wakeup. The issuing entry has no pending operand, so it never
        // matches here; free entries are excluded by the busy check.
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i] && qj_busy_q[i]) begin
            if (cdbA_valid && (cdbA_rob_id == qj_q[i])) begin
              vj_q[i]      <= cdbA_value;
              qj_busy_q[i] <= 1'b0;
            end else if (cdbB_valid && (cdbB_rob_id == qj_q[i])) begin
              vj_q[i]      <= cdbB_value;
              qj_busy_q[i] <= 1'b0;
            end
          end
          if (busy_q[i] && qk_busy_q[i]) begin
            if (cdbA_valid && (cdbA_rob_id == qk_q[i])) begin
              vk_q[i]      <= cdbA_value;
              qk_busy_q[i] <= 1'b0;
            end else if (cdbB_valid && (cdbB_rob_id == qk_q[i])) begin
              vk_q[i]      <= cdbB_value;
              qk_busy_q[i] <= 1'b0;
            end
          end
        end

        // Dispatch into a slot that is free in registered state; a slot being
        // vacated by issue this edge is never chosen, so no write conflict.
        if (disp_valid && free_hit) begin
          busy_q[free_idx]    <= 1'b1;
          opcode_q[free_idx]  <= disp_opcode;
          rob_id_q[free_idx]  <= disp_rob_id;
          pc_q[free_idx]      <= disp_pc;
          imm_q[free_idx]     <= disp_imm;
          vj_q[free_idx]      <= byp_vj;
          vk_q[free_idx]      <= byp_vk;
          qj_busy_q[free_idx] <= byp_qj_busy;
          qk_busy_q[free_idx] <= byp_qk_busy;
          qj_q[free_idx]      <= disp_qj;
          qk_q[free_idx]      <= disp_qk;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_station.sv
module tb_alu_issue_station;

  localparam int N = 8;
  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h01;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        rdy, clear, disp_valid;
  logic [5:0]  disp_opcode;
  logic [3:0]  disp_rob_id, disp_qj, disp_qk;
  logic [31:0] disp_pc, disp_imm, disp_vj, disp_vk;
  logic        disp_qj_busy, disp_qk_busy;
  logic        full;
  logic        cdbA_valid, cdbB_valid;
  logic [3:0]  cdbA_rob_id, cdbB_rob_id;
  logic [31:0] cdbA_value, cdbB_value;
  logic        alu_en;
  logic [3:0]  alu_rob_id;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_rs1, alu_rs2, alu_imm, alu_pc;

  alu_issue_station #(.RS_SIZE(N), .ROB_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .disp_valid(disp_valid), .disp_opcode(disp_opcode), .disp_rob_id(disp_rob_id),
    .disp_pc(disp_pc), .disp_imm(disp_imm), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_qj_busy(disp_qj_busy), .disp_qj(disp_qj),
    .disp_qk_busy(disp_qk_busy), .disp_qk(disp_qk),
    .full(full),
    .cdbA_valid(cdbA_valid), .cdbA_rob_id(cdbA_rob_id), .cdbA_value(cdbA_value),
    .cdbB_valid(cdbB_valid), .cdbB_rob_id(cdbB_rob_id), .cdbB_value(cdbB_value),
    .alu_en(alu_en), .alu_rob_id(alu_rob_id), .alu_opcode(alu_opcode),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm), .alu_pc(alu_pc)
  );

  // ---------------- scoreboard ----------------
  logic [137:0] exp_q[$];   // {rob, opcode, rs1, rs2, imm, pc}
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [137:0] act, input logic [137:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The station as a set of slots, each an op waiting for its operands.
  typedef struct {
    logic        busy;
    logic [5:0]  op;
    logic [3:0]  rob;
    logic [31:0] pc, imm, vj, vk;
    logic        qjb, qkb;
    logic [3:0]  qj, qk;
  } ent_t;

  ent_t m[N];
  logic m_en;
  logic m_full;

  function automatic bit cdb_hit(input logic [3:0] t, output logic [31:0] v);
    v = '0;
    if (cdbA_valid && cdbA_rob_id == t) begin v = cdbA_value; return 1'b1; end
    if (cdbB_valid && cdbB_rob_id == t) begin v = cdbB_value; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic bit all_busy();
    for (int i = 0; i < N; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m[i].busy = 1'b0;
    m_en   = 1'b0;
    m_full = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs now on the pins.
  task automatic model_step();
    ent_t nxt[N];
    ent_t e;
    int iss, fr;
    logic [31:0] v;
    if (!rdy) return;
    if (clear) begin
      model_reset();
      return;
    end
    nxt = m;
    iss = -1;
    for (int i = 0; i < N; i++)
      if (iss < 0 && m[i].busy && !m[i].qjb && !m[i].qkb) iss = i;
    if (iss >= 0) begin
      exp_q.push_back({m[iss].rob, m[iss].op, m[iss].vj, m[iss].vk, m[iss].imm, m[iss].pc});
      nxt[iss].busy = 1'b0;
      m_en = 1'b1;
    end else begin
      m_en = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (m[i].busy && i != iss) begin
        if (m[i].qjb && cdb_hit(m[i].qj, v)) begin nxt[i].vj = v; nxt[i].qjb = 1'b0; end
        if (m[i].qkb && cdb_hit(m[i].qk, v)) begin nxt[i].vk = v; nxt[i].qkb = 1'b0; end
      end
    end
    fr = -1;
    for (int i = 0; i < N; i++) if (fr < 0 && !m[i].busy) fr = i;
    if (disp_valid && fr >= 0) begin
      e.busy = 1'b1; e.op = disp_opcode; e.rob = disp_rob_id;
      e.pc = disp_pc; e.imm = disp_imm;
      e.vj = disp_vj; e.qjb = disp_qj_busy; e.qj = disp_qj;
      e.vk = disp_vk; e.qkb = disp_qk_busy; e.qk = disp_qk;
      if (e.qjb && cdb_hit(e.qj, v)) begin e.vj = v; e.qjb = 1'b0; end
      if (e.qkb && cdb_hit(e.qk, v)) begin e.vk = v; e.qkb = 1'b0; end
      nxt[fr] = e;
    end
    m = nxt;
    m_full = all_busy();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    rdy = 1'b1; clear = 1'b0; disp_valid = 1'b0;
    disp_opcode = '0; disp_rob_id = '0; disp_pc = '0; disp_imm = '0;
    disp_vj = '0; disp_vk = '0; disp_qj_busy = 1'b0; disp_qk_busy = 1'b0;
    disp_qj = '0; disp_qk = '0;
    cdbA_valid = 1'b0; cdbA_rob_id = '0; cdbA_value = '0;
    cdbB_valid = 1'b0; cdbB_rob_id = '0; cdbB_value = '0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [3:0] rob,
                      input logic [31:0] vj, input logic qjb, input logic [3:0] qj,
                      input logic [31:0] vk, input logic qkb, input logic [3:0] qk);
    disp_valid = 1'b1; disp_opcode = op; disp_rob_id = rob;
    disp_pc = $urandom; disp_imm = $urandom;
    disp_vj = vj; disp_qj_busy = qjb; disp_qj = qj;
    disp_vk = vk; disp_qk_busy = qkb; disp_qk = qk;
  endtask

  // Apply current inputs for one edge, then return at the next negedge.
  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n);
    idle();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_alu_en", alu_en, 0);
    chk("rst_full",   full,   0);
    chk("rst_rob_id", alu_rob_id, 0);
    chk("rst_opcode", alu_opcode, 0);
    chk("rst_rs1",    alu_rs1, 0);
    chk("rst_rs2",    alu_rs2, 0);
    chk("rst_imm",    alu_imm, 0);
    chk("rst_pc",     alu_pc,  0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rand_inputs(input int rdy_pct, input int clr_per);
    idle();
    rdy   = ($urandom_range(0, 99) < rdy_pct);
    clear = ($urandom_range(0, clr_per - 1) == 0);
    if ($urandom_range(0, 9) < 6)
      disp($urandom_range(0, 63), $urandom_range(0, 15),
           $urandom, $urandom_range(0, 1), $urandom_range(0, 15),
           $urandom, $urandom_range(0, 1), $urandom_range(0, 15));
    cdbA_valid = ($urandom_range(0, 9) < 4);
    cdbA_rob_id = $urandom_range(0, 15);
    cdbA_value = $urandom;
    cdbB_valid = ($urandom_range(0, 9) < 3);
    cdbB_rob_id = $urandom_range(0, 15);
    cdbB_value = $urandom;
    // Two buses never carry the same tag at once (tags are unique in flight).
    if (cdbA_valid && cdbB_valid && cdbA_rob_id == cdbB_rob_id) cdbB_rob_id = cdbA_rob_id ^ 4'h1;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic rdy_s, rst_s;
    logic [137:0] got;
    rdy_s = rdy;
    rst_s = rst;
    #1;
    if (rst_s && rst) begin
      chk("alu_en", alu_en, m_en);
      chk("full",   full,   m_full);
      if (alu_en && rdy_s) begin
        got = {alu_rob_id, alu_opcode, alu_rs1, alu_rs2, alu_imm, alu_pc};
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL issue: unexpected op %h, none expected (t=%0t)", got, $time);
        end else begin
          chk("issue", got, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle();
    model_reset();
    do_reset();

    // Ready op: issues two edges after dispatch.
    disp(OP_ADD, 4'd3, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0);
    step();
    idle_steps(4);

    // Wait on tag 1, woken by cdbA three cycles later.
    disp(OP_ADDI, 4'd2, 32'd0, 1'b1, 4'd1, 32'd0, 1'b0, 4'd0);
    step();
    idle_steps(3);
    cdbA_valid = 1'b1; cdbA_rob_id = 4'd1; cdbA_value = 32'h10;
    step();
    idle_steps(4);

    // Same-cycle bypass from cdbB.
    disp(OP_ADD, 4'd6, 32'd0, 1'b1, 4'd4, 32'd9, 1'b0, 4'd0);
    cdbB_valid = 1'b1; cdbB_rob_id = 4'd4; cdbB_value = 32'hAB;
    step();
    idle_steps(4);

    // Fill all slots waiting on tag 9, a ninth dispatch is dropped, then wake all.
    for (int i = 0; i < N + 1; i++) begin
      idle();
      disp(OP_ADD, 4'(i), $urandom, 1'b1, 4'd9, $urandom, 1'b0, 4'd0);
      step();
    end
    idle();
    cdbA_valid = 1'b1; cdbA_rob_id = 4'd9; cdbA_value = 32'd1;
    step();
    idle_steps(N + 3);

    // Both buses hit one slot (j from A, k from B).
    disp(OP_ADD, 4'd12, 32'd0, 1'b1, 4'd7, 32'd0, 1'b1, 4'd8);
    step();
    idle();
    cdbA_valid = 1'b1; cdbA_rob_id = 4'd7; cdbA_value = 32'h1111;
    cdbB_valid = 1'b1; cdbB_rob_id = 4'd8; cdbB_value = 32'h2222;
    step();
    idle_steps(3);

    // Three waiting slots flushed; their producer later broadcasts, nothing issues.
    for (int i = 0; i < 3; i++) begin
      idle();
      disp(OP_ADDI, 4'(i + 4), 32'd0, 1'b1, 4'd5, 32'd1, 1'b0, 4'd0);
      step();
    end
    idle(); clear = 1'b1;
    disp(OP_ADD, 4'd15, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0);
    step();
    idle(); cdbA_valid = 1'b1; cdbA_rob_id = 4'd5; cdbA_value = 32'h55;
    step();
    idle_steps(3);

    // Freeze with a ready op pending, then resume.
    disp(OP_ADD, 4'd8, 32'h77, 1'b0, 4'd0, 32'h88, 1'b0, 4'd0);
    step();
    idle(); rdy = 1'b0;
    for (int i = 0; i < 4; i++) step();
    idle_steps(4);

    // Randomized traffic with a reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if (i < 1000) rand_inputs(90, 60);
      else rand_inputs(75, 200);
      step();
    end
    idle_steps(6);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected ops never issued", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
